core_sched: RTL and testbench



---
 rtl/core_sched_cnt.sv | 66 ++++++
 rtl/core_sched.sv | 106 ++++++++++
 tb/tb_core_sched.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sched_cnt.sv
// Cascaded slot / core / context wrap counter for core_sched.
// epoch_carry is high for the step right after the last cycle of an epoch.
module core_sched_cnt #(
  parameter int N_CORES       = 3,
  parameter int N_CTX         = 2,
  parameter int COMP_INTERVAL = 24,
  parameter int CNT_W         = 5,
  parameter int CORE_W        = 2,
  parameter int CTX_W         = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              en,
  output logic [CNT_W-1:0]  cnt,
  output logic [CORE_W-1:0] core_idx,
  output logic [CTX_W-1:0]  ctx_idx,
  output logic              epoch_carry
);

  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [CORE_W-1:0] core_r, core_nxt_s;
  logic [CTX_W-1:0]  ctx_r, ctx_nxt_s;
  logic              carry_r;
  logic              cnt_last_s, core_last_s, ctx_last_s;

  // next-count cascade: slot counter carries into core index, core into context
  always_comb begin
    cnt_last_s  = (cnt_r == CNT_W'(COMP_INTERVAL - 1));
    core_last_s = (core_r == CORE_W'(N_CORES - 1));
    ctx_last_s  = (ctx_r == CTX_W'(N_CTX - 1));
    cnt_nxt_s   = cnt_last_s ? '0 : cnt_r + CNT_W'(1);
    core_nxt_s  = core_r;
    ctx_nxt_s   = ctx_r;
    if (cnt_last_s) begin
      core_nxt_s = core_last_s ? '0 : core_r + CORE_W'(1);
      if (core_last_s) begin
        ctx_nxt_s = ctx_last_s ? '0 : ctx_r + CTX_W'(1);
      end else begin
        ctx_nxt_s = ctx_r;
      end
    end else begin
      core_nxt_s = core_r;
    end
  end

  // counter state; holds while en is low
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r   <= '0;
      core_r  <= '0;
      ctx_r   <= '0;
      carry_r <= 1'b0;
    end else if (en) begin
      cnt_r   <= cnt_nxt_s;
      core_r  <= core_nxt_s;
      ctx_r   <= ctx_nxt_s;
      carry_r <= cnt_last_s && core_last_s && ctx_last_s;
    end
  end

  assign cnt         = cnt_r;
  assign core_idx    = core_r;
  assign ctx_idx     = ctx_r;
  assign epoch_carry = carry_r;

endmodule

// File: rtl/core_sched.sv
// Start-pulse scheduler for N_CORES md5 cores over N_CTX contexts, one
// start per core per context, with freeze, per-core masking and epoch pulse.
module core_sched #(
  parameter int   N_CORES       = 3,
  parameter int   N_CTX         = 2,
  parameter int   TOTAL_CYCLES  = 288,
  parameter int   N_THREADS     = 12,
  parameter int   COMP_INTERVAL = TOTAL_CYCLES / N_THREADS,
  parameter logic SEQ_INIT      = 1'b1,
  localparam int  CTX_W         = (N_CTX > 1) ? $clog2(N_CTX) : 1,
  localparam int  CORE_W        = (N_CORES > 1) ? $clog2(N_CORES) : 1,
  localparam int  CNT_W         = (COMP_INTERVAL > 1) ? $clog2(COMP_INTERVAL) : 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               en,
  input  logic [N_CORES-1:0] core_mask,
  output logic [N_CORES-1:0] core_start,
  output logic [CTX_W-1:0]   ctx_num,
  output logic [N_CORES-1:0] seq_num,
  output logic [CORE_W-1:0]  start_core,
  output logic [CTX_W-1:0]   start_ctx,
  output logic               epoch_done
);

  if (COMP_INTERVAL % N_CTX != 0) begin : g_bad_div
    $error("core_sched: COMP_INTERVAL must be a multiple of N_CTX");
  end
  if (COMP_INTERVAL < N_CTX) begin : g_bad_interval
    $error("core_sched: COMP_INTERVAL must be at least N_CTX");
  end
  if (N_CTX < 2) begin : g_bad_ctx
    $error("core_sched: N_CTX must be at least 2");
  end

  logic [CNT_W-1:0]   cnt_s;
  logic [CORE_W-1:0]  core_idx_s;
  logic [CTX_W-1:0]   ctx_idx_s;
  logic               carry_s;
  logic [N_CORES-1:0] start_vec_s;
  logic [CTX_W-1:0]   ctx_nxt_s;

  logic [N_CORES-1:0] core_start_r;
  logic [CTX_W-1:0]   ctx_num_r;
  logic [N_CORES-1:0] seq_num_r;
  logic [CORE_W-1:0]  start_core_r;
  logic [CTX_W-1:0]   start_ctx_r;
  logic               epoch_done_r;

  core_sched_cnt #(
    .N_CORES       (N_CORES),
    .N_CTX         (N_CTX),
    .COMP_INTERVAL (COMP_INTERVAL),
    .CNT_W         (CNT_W),
    .CORE_W        (CORE_W),
    .CTX_W         (CTX_W)
  ) u_cnt (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .en          (en),
    .cnt         (cnt_s),
    .core_idx    (core_idx_s),
    .ctx_idx     (ctx_idx_s),
    .epoch_carry (carry_s)
  );

  // start fires at offset ctx_idx inside the slot, so ctx_num equals start_ctx then
  always_comb begin
    start_vec_s = '0;
    for (int i = 0; i < N_CORES; i++) begin
      start_vec_s[i] = (core_idx_s == CORE_W'(i)) && core_mask[i] &&
                       (cnt_s == CNT_W'(ctx_idx_s));
    end
    ctx_nxt_s = (ctx_num_r == CTX_W'(N_CTX - 1)) ? '0 : ctx_num_r + CTX_W'(1);
  end

  // output registers; pulses drop while frozen, everything else holds
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      core_start_r <= '0;
      ctx_num_r    <= CTX_W'(N_CTX - 1);
      seq_num_r    <= {N_CORES{SEQ_INIT}};
      start_core_r <= '0;
      start_ctx_r  <= '0;
      epoch_done_r <= 1'b0;
    end else if (en) begin
      core_start_r <= start_vec_s;
      ctx_num_r    <= ctx_nxt_s;
      seq_num_r    <= carry_s ? ~seq_num_r : seq_num_r;
      start_core_r <= core_idx_s;
      start_ctx_r  <= ctx_idx_s;
      epoch_done_r <= carry_s;
    end else begin
      core_start_r <= '0;
      epoch_done_r <= 1'b0;
    end
  end

  assign core_start = core_start_r;
  assign ctx_num    = ctx_num_r;
  assign seq_num    = seq_num_r;
  assign start_core = start_core_r;
  assign start_ctx  = start_ctx_r;
  assign epoch_done = epoch_done_r;

endmodule

// File: tb/tb_core_sched.sv
// Self-checking bench for core_sched: closed-form scoreboard, directed
// vector table and hand-written freeze / reset sequences.
module tb_core_sched;

  typedef struct {
    int cs;
    int sc;
    int sx;
    int ctx;
    int seq;
    int ed;
  } exp_t;

  typedef struct {
    int dut;
    int k;
    int cs;
    int sc;
    int sx;
    int ctx;
    int seq;
    int ed;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       en;
  logic       en2;
  logic [2:0] core_mask;
  logic [1:0] mask2;

  logic [2:0] cs1;
  logic [0:0] ctx1;
  logic [2:0] seq1;
  logic [1:0] sc1;
  logic [0:0] sx1;
  logic       ed1;

  logic [1:0] cs2;
  logic [1:0] ctx2;
  logic [1:0] seq2;
  logic [0:0] sc2;
  logic [1:0] sx2;
  logic       ed2;

  int n_checks = 0;
  int n_errors = 0;
  int k1, k2;
  exp_t e1, e2;

  core_sched dut1 (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .en         (en),
    .core_mask  (core_mask),
    .core_start (cs1),
    .ctx_num    (ctx1),
    .seq_num    (seq1),
    .start_core (sc1),
    .start_ctx  (sx1),
    .epoch_done (ed1)
  );

  core_sched #(
    .N_CORES      (2),
    .N_CTX        (4),
    .TOTAL_CYCLES (64),
    .N_THREADS    (8)
  ) dut2 (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .en         (en2),
    .core_mask  (mask2),
    .core_start (cs2),
    .ctx_num    (ctx2),
    .seq_num    (seq2),
    .start_core (sc2),
    .start_ctx  (sx2),
    .epoch_done (ed2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int k, input int nc, input int nctx,
                                 input int ci, input int mask);
    exp_t r;
    int s, ep;
    ep    = ci * nc * nctx;
    s     = k / ci;
    r.ctx = k % nctx;
    r.sc  = s % nc;
    r.sx  = (s / nc) % nctx;
    r.cs  = ((k % ci) == r.sx && ((mask >> r.sc) & 1) == 1) ? (1 << r.sc) : 0;
    r.seq = ((k / ep) % 2 == 1) ? 0 : ((1 << nc) - 1);
    r.ed  = (k > 0 && (k % ep) == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic reset_model();
    k1 = 0;
    k2 = 0;
    e1 = '{cs: 0, sc: 0, sx: 0, ctx: 1, seq: 7, ed: 0};
    e2 = '{cs: 0, sc: 0, sx: 0, ctx: 3, seq: 3, ed: 0};
  endtask

  task automatic cmp_all();
    chk("dut1 core_start", int'(cs1), e1.cs);
    chk("dut1 start_core", int'(sc1), e1.sc);
    chk("dut1 start_ctx", int'(sx1), e1.sx);
    chk("dut1 ctx_num", int'(ctx1), e1.ctx);
    chk("dut1 seq_num", int'(seq1), e1.seq);
    chk("dut1 epoch_done", int'(ed1), e1.ed);
    chk("dut1 onehot", ($countones(cs1) <= 1) ? 1 : 0, 1);
    chk("dut2 core_start", int'(cs2), e2.cs);
    chk("dut2 start_core", int'(sc2), e2.sc);
    chk("dut2 start_ctx", int'(sx2), e2.sx);
    chk("dut2 ctx_num", int'(ctx2), e2.ctx);
    chk("dut2 seq_num", int'(seq2), e2.seq);
    chk("dut2 epoch_done", int'(ed2), e2.ed);
  endtask

  // one clock edge: inputs are sampled before it, outputs compared #1 after it
  task automatic step();
    logic en_s, en2_s;
    int   m1, m2;
    en_s  = en;
    en2_s = en2;
    m1    = int'(core_mask);
    m2    = int'(mask2);
    @(posedge CLK);
    #1;
    if (en_s) begin
      e1 = model(k1, 3, 2, 24, m1);
      k1++;
    end else begin
      e1.cs = 0;
      e1.ed = 0;
    end
    if (en2_s) begin
      e2 = model(k2, 2, 4, 8, m2);
      k2++;
    end else begin
      e2.cs = 0;
      e2.ed = 0;
    end
    cmp_all();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    en    = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    reset_model();
    cmp_all();
    @(negedge CLK);
    RST_N = 1'b1;
    en    = 1'b1;
  endtask

  vec_t tab[$];
  int   hits;
  int   found;
  int   edge_idx;
  int   guard;

  initial begin
    tab = '{
      '{1, 0,   1, 0, 0, 0, 7, 0},
      '{1, 1,   0, 0, 0, 1, 7, 0},
      '{1, 24,  2, 1, 0, 0, 7, 0},
      '{1, 48,  4, 2, 0, 0, 7, 0},
      '{1, 72,  0, 0, 1, 0, 7, 0},
      '{1, 73,  1, 0, 1, 1, 7, 0},
      '{1, 97,  2, 1, 1, 1, 7, 0},
      '{1, 121, 4, 2, 1, 1, 7, 0},
      '{1, 143, 0, 2, 1, 1, 7, 0},
      '{1, 144, 1, 0, 0, 0, 0, 1},
      '{1, 145, 0, 0, 0, 1, 0, 0},
      '{2, 0,   1, 0, 0, 0, 3, 0},
      '{2, 8,   2, 1, 0, 0, 3, 0},
      '{2, 17,  1, 0, 1, 1, 3, 0},
      '{2, 25,  2, 1, 1, 1, 3, 0},
      '{2, 34,  1, 0, 2, 2, 3, 0},
      '{2, 42,  2, 1, 2, 2, 3, 0},
      '{2, 51,  1, 0, 3, 3, 3, 0},
      '{2, 59,  2, 1, 3, 3, 3, 0},
      '{2, 63,  0, 1, 3, 3, 3, 0},
      '{2, 64,  1, 0, 0, 0, 0, 1}
    };
    RST_N     = 1'b0;
    en        = 1'b0;
    en2       = 1'b1;
    core_mask = 3'b111;
    mask2     = 2'b11;
    reset_model();

    // directed table against both parameterisations
    do_reset();
    for (int step_k = 0; step_k < 150; step_k++) begin
      step();
      foreach (tab[i]) begin
        if (tab[i].k == step_k && tab[i].dut == 1) begin
          chk("tab1 core_start", int'(cs1), tab[i].cs);
          chk("tab1 start_core", int'(sc1), tab[i].sc);
          chk("tab1 start_ctx", int'(sx1), tab[i].sx);
          chk("tab1 ctx_num", int'(ctx1), tab[i].ctx);
          chk("tab1 seq_num", int'(seq1), tab[i].seq);
          chk("tab1 epoch_done", int'(ed1), tab[i].ed);
        end
        if (tab[i].k == step_k && tab[i].dut == 2) begin
          chk("tab2 core_start", int'(cs2), tab[i].cs);
          chk("tab2 start_core", int'(sc2), tab[i].sc);
          chk("tab2 start_ctx", int'(sx2), tab[i].sx);
          chk("tab2 ctx_num", int'(ctx2), tab[i].ctx);
          chk("tab2 seq_num", int'(seq2), tab[i].seq);
          chk("tab2 epoch_done", int'(ed2), tab[i].ed);
        end
      end
    end

    // masked core 1: slot still consumed, no pulse to it
    do_reset();
    core_mask = 3'b101;
    hits = 0;
    for (int step_k = 0; step_k < 150; step_k++) begin
      step();
      if (cs1[1]) hits++;
      if (step_k == 30) chk("mask start_core", int'(sc1), 1);
      if (step_k == 144) chk("mask epoch_done", int'(ed1), 1);
    end
    chk("mask core1 pulses", hits, 0);
    core_mask = 3'b111;

    // freeze for 10 edges after k=22; core1 start slips by exactly the pause
    do_reset();
    edge_idx = 0;
    for (int i = 0; i < 23; i++) begin
      step();
      edge_idx++;
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      edge_idx++;
      chk("pause no pulse", int'(cs1), 0);
      chk("pause ctx frozen", int'(ctx1), 0);
    end
    en = 1'b1;
    found = -1;
    for (int i = 0; i < 60 && found < 0; i++) begin
      step();
      if (cs1[1]) found = edge_idx;
      edge_idx++;
    end
    chk("pause core1 edge", found, 34);

    // async reset while core_start[2] is high
    do_reset();
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (cs1 == 3'b100) found = 1;
    end
    chk("reach core2 pulse", found, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async rst core_start", int'(cs1), 0);
    chk("async rst ctx_num", int'(ctx1), 1);
    chk("async rst seq_num", int'(seq1), 7);
    reset_model();
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    chk("restart core_start", int'(cs1), 1);
    chk("restart seq_num", int'(seq1), 7);

    // ten epochs of random enable and mask against the scoreboard
    do_reset();
    guard = 0;
    while (k1 < 1440 && guard < 4000) begin
      en        = ($urandom_range(0, 3) != 0);
      core_mask = 3'($urandom_range(0, 7));
      step();
      guard++;
    end
    chk("random run reached 10 epochs", (k1 >= 1440) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
